// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared pixel type, screen geometry and frame-buffer addressing for the render blocks
package render_pkg;

    typedef logic [15:0] rgb565_t;

    localparam int      SCREEN_W        = 640;
    localparam int      SCREEN_H        = 480;
    localparam rgb565_t TRANSPARENT_DEF = 16'hF81F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    function automatic logic [18:0] fb_addr(input logic [10:0] x, input logic [10:0] y,
                                            input int w = SCREEN_W);
        return 19'(int'(y) * w + int'(x));
    endfunction

endpackage

// File: rtl/render_scan_ctr.sv
// rtl/render_scan_ctr.sv - nested digit/row/column scan counters with scale sub-counters
module render_scan_ctr
    import render_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int GLYPH_W   = 12,
    parameter int GLYPH_H   = 18,
    parameter int MAX_SCALE = 4,
    parameter int DW        = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    parameter int SROW_W    = $clog2(GLYPH_H),
    parameter int SCOL_W    = $clog2(GLYPH_W),
    parameter int DROW_W    = $clog2(GLYPH_H * MAX_SCALE),
    parameter int DCOL_W    = $clog2(GLYPH_W * MAX_SCALE)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              en,
    input  logic [2:0]        s,
    output logic [DW-1:0]     digit,
    output logic [SROW_W-1:0] srow,
    output logic [SCOL_W-1:0] scol,
    output logic [DROW_W-1:0] drow,
    output logic [DCOL_W-1:0] dcol,
    output logic              last
);

    logic [2:0] csub;
    logic [2:0] rsub;
    logic       col_sub_wrap, col_wrap, row_sub_wrap, row_wrap;

    // Each wrap qualifies the next level out, so one cycle advances exactly one destination pixel.
    assign col_sub_wrap = (csub == s - 3'd1);
    assign col_wrap     = col_sub_wrap && (scol == SCOL_W'(GLYPH_W - 1));
    assign row_sub_wrap = col_wrap && (rsub == s - 3'd1);
    assign row_wrap     = row_sub_wrap && (srow == SROW_W'(GLYPH_H - 1));
    assign last         = row_wrap && (digit == DW'(DIGITS - 1));

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            csub  <= '0;
            rsub  <= '0;
            scol  <= '0;
            srow  <= '0;
            dcol  <= '0;
            drow  <= '0;
            digit <= '0;
        end else if (en) begin
            csub <= col_sub_wrap ? '0 : csub + 1'b1;
            dcol <= col_wrap ? '0 : dcol + 1'b1;
            if (col_sub_wrap)
                scol <= col_wrap ? '0 : scol + 1'b1;
            if (col_wrap) begin
                rsub <= row_sub_wrap ? '0 : rsub + 1'b1;
                drow <= row_wrap ? '0 : drow + 1'b1;
            end
            if (row_sub_wrap)
                srow <= row_wrap ? '0 : srow + 1'b1;
            if (row_wrap)
                digit <= last ? '0 : digit + 1'b1;
        end
    end

endmodule

// File: rtl/render_number.sv
// rtl/render_number.sv - scaled, clipped, colour-keyed BCD number blitter into the RGB565 frame buffer
module render_number
    import render_pkg::*;
#(
    parameter int      DIGITS      = 4,
    parameter int      GLYPH_W     = 12,
    parameter int      GLYPH_H     = 18,
    parameter int      SPACING     = 2,
    parameter int      MAX_SCALE   = 4,
    parameter int      SCREEN_W    = 640,
    parameter int      SCREEN_H    = 480,
    parameter int      ROM_AW      = 12,
    parameter rgb565_t TRANSPARENT = TRANSPARENT_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [DIGITS*4-1:0] value,
    input  logic [9:0]          top,
    input  logic [9:0]          left,
    input  logic [2:0]          scale,
    input  logic                blank_lz,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [15:0]         rom_data,
    output logic [18:0]         dst_addr,
    output logic [15:0]         dst_data,
    output logic                dst_wr,
    output logic                busy,
    output logic                done
);

    localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NSLOT  = 1 << DW;
    localparam int SROW_W = $clog2(GLYPH_H);
    localparam int SCOL_W = $clog2(GLYPH_W);
    localparam int DROW_W = $clog2(GLYPH_H * MAX_SCALE);
    localparam int DCOL_W = $clog2(GLYPH_W * MAX_SCALE);

    state_t state, state_nxt;

    logic [3:0]       nib_q   [NSLOT];
    logic [3:0]       nib_new [NSLOT];
    logic [NSLOT-1:0] blank_q, blank_new;
    logic [9:0]       top_q, left_q;
    logic [2:0]       s_q, s_eff;
    logic             seen, accept, last;

    logic [DW-1:0]     digit;
    logic [SROW_W-1:0] srow;
    logic [SCOL_W-1:0] scol;
    logic [DROW_W-1:0] drow;
    logic [DCOL_W-1:0] dcol;

    logic        p1_valid, p1_blank;
    logic [10:0] p1_x, p1_y;

    assign accept = (state == S_IDLE) && start;

    always_comb begin
        s_eff = scale;
        if (scale == 3'd0)
            s_eff = 3'd1;
        else if (scale > 3'(MAX_SCALE))
            s_eff = 3'(MAX_SCALE);
    end

    // Slot k is the k-th digit from the left; the rightmost digit is never lead-blanked.
    always_comb begin
        seen      = 1'b0;
        blank_new = '0;
        for (int k = 0; k < NSLOT; k++)
            nib_new[k] = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            nib_new[k]   = value[(DIGITS-1-k)*4 +: 4];
            blank_new[k] = (nib_new[k] > 4'd9) ||
                           (blank_lz && !seen && nib_new[k] == 4'h0 && k != DIGITS - 1);
            seen         = seen | (nib_new[k] != 4'h0);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN) || (state == S_FLUSH);
    assign done = (state == S_DONE);

    render_scan_ctr #(
        .DIGITS(DIGITS), .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .MAX_SCALE(MAX_SCALE),
        .DW(DW), .SROW_W(SROW_W), .SCOL_W(SCOL_W), .DROW_W(DROW_W), .DCOL_W(DCOL_W)
    ) u_scan (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (accept),
        .en    (state == S_RUN),
        .s     (s_q),
        .digit (digit),
        .srow  (srow),
        .scol  (scol),
        .drow  (drow),
        .dcol  (dcol),
        .last  (last)
    );

    assign rom_addr = ROM_AW'(int'(nib_q[digit]) * (GLYPH_W * GLYPH_H) +
                              int'(srow) * GLYPH_W + int'(scol));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            top_q   <= '0;
            left_q  <= '0;
            s_q     <= '0;
            blank_q <= '0;
            for (int k = 0; k < NSLOT; k++)
                nib_q[k] <= '0;
            p1_valid <= 1'b0;
            p1_blank <= 1'b0;
            p1_x     <= '0;
            p1_y     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                nib_q   <= nib_new;
                blank_q <= blank_new;
                top_q   <= top;
                left_q  <= left;
                s_q     <= s_eff;
            end
            // 11-bit coordinates keep off-screen pixels from aliasing back onto the screen.
            p1_valid <= (state == S_RUN);
            p1_blank <= blank_q[digit];
            p1_x     <= 11'(int'(left_q) + int'(digit) * (GLYPH_W + SPACING) * int'(s_q) + int'(dcol));
            p1_y     <= 11'(int'(top_q) + int'(drow));
        end
    end

    assign dst_wr   = p1_valid && !p1_blank && (p1_x < 11'(SCREEN_W)) && (p1_y < 11'(SCREEN_H)) &&
                      (rom_data != TRANSPARENT);
    assign dst_data = p1_valid ? rom_data : 16'h0000;
    assign dst_addr = fb_addr(p1_x, p1_y, SCREEN_W);

endmodule

// File: doc/render_number.md
Name: render_number

Overview:
- Parametrised glyph blitter. Draws a multi-digit BCD number into the RGB565 frame buffer.
- Supports integer upscaling, a transparent colour key, leading-zero blanking and screen-edge clipping.
- Sits between the game/UI controller (start/busy/done handshake) and the frame-buffer write port.
- Reads glyph pixels from the shared digit ROM, which is external and has 1-cycle read latency.

Parameters:
- DIGITS, 4, number of BCD digits rendered per request.
- GLYPH_W, 12, glyph width in source pixels.
- GLYPH_H, 18, glyph height in source pixels.
- SPACING, 2, gap between glyphs in source pixels; scaled with the glyph.
- MAX_SCALE, 4, largest accepted scale factor.
- SCREEN_W, 640, frame-buffer width.
- SCREEN_H, 480, frame-buffer height.
- ROM_AW, 12, digit ROM address width; glyph d starts at d*GLYPH_W*GLYPH_H.
- TRANSPARENT, 16'hF81F, colour key; pixels of this colour are never written.

Ports:
- clk  in  1  system clock, 100 MHz.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle request pulse; ignored while busy.
- value  in  DIGITS*4  BCD value; most significant digit in the top nibble.
- top  in  10  y of the glyph top-left corner.
- left  in  10  x of the glyph top-left corner.
- scale  in  3  upscale factor; 0 is treated as 1; values above MAX_SCALE are clamped to MAX_SCALE.
- blank_lz  in  1  1 = leading zeros are not drawn.
- rom_addr  out  ROM_AW  glyph ROM address.
- rom_data  in  16  ROM pixel, valid the cycle after rom_addr.
- dst_addr  out  19  frame-buffer address, y*SCREEN_W + x.
- dst_data  out  16  pixel colour.
- dst_wr  out  1  write strobe.
- busy  out  1  render in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: rstn=0 at a clock edge forces state IDLE, all counters 0, busy=0, done=0, dst_wr=0, rom_addr=0, dst_addr=0, dst_data=0. Reset mid-render aborts with no further writes and no done pulse.
- States:
  - IDLE -> RUN on start.
  - RUN -> FLUSH after the last pixel address is issued.
  - FLUSH -> DONE after one cycle.
  - DONE -> IDLE after one cycle.
  - busy=1 in RUN and FLUSH; done=1 only in DONE.
- Input capture: value, top, left, effective scale (S) and blank_lz are registered on the accepted start. Later input changes do not affect a render in flight.
- Scan order:
  - Digits from MSB to LSB, left to right.
  - Within a glyph, destination rows top to bottom; within a row, columns left to right.
  - One destination pixel per RUN cycle; total pixels N = DIGITS*GLYPH_W*GLYPH_H*S*S.
- Sub-pixel counters replace dividers: column and row sub-counters run 0..S-1. The source column/row advances when its sub-counter wraps.
- Addressing:
  - rom_addr = digit*GLYPH_W*GLYPH_H + srow*GLYPH_W + scol.
  - Destination x = left + k*(GLYPH_W+SPACING)*S + dcol.
  - Destination y = top + drow.
  - k is the digit index from the left; x and y are computed at 11 bits so nothing wraps.
- Pipeline: the stage-1 address and coordinates are registered alongside the ROM access. In stage 2, dst_addr, dst_data=rom_data and dst_wr are presented together.
- dst_wr=1 only when all of the following hold:
  - x < SCREEN_W and y < SCREEN_H (clipped pixels are silently dropped);
  - rom_data != TRANSPARENT;
  - the digit is not blanked.
- A digit is blanked when:
  - its nibble is > 9; or
  - blank_lz=1 and it is a zero to the left of the first non-zero digit.
  - The LSB digit is never blanked by blank_lz.
- Blanked digits are still scanned (writes suppressed), so latency is fixed.
- Timing, with start accepted at cycle 0:
  - RUN spans cycles 1..N.
  - First dst_wr candidate at cycle 2; last at cycle N+1 (FLUSH).
  - done at cycle N+2.
  - start arriving in the same cycle as done is ignored; it is accepted in IDLE the following cycle.

Decomposition:
- Package render_pkg holds the RGB565 type, SCREEN_W/SCREEN_H, the TRANSPARENT default and the fb_addr(x,y) function, shared with render_pixel users.
- One sub-module, render_scan_ctr: nested digit/row/column counters with scale sub-counters, producing digit index, srow, scol, drow, dcol and last.

Test Plan:
- Single digit, no scaling. DIGITS=1, value=4'h0, top=10, left=20, S=1, ROM all 16'h07E0 -> 216 writes, first dst_addr=6420, last dst_addr=27*640+31=17311, done at cycle 218.
- Scale 2. Same setup with S=2 -> 864 writes; each source pixel appears on a 2x2 block; addresses 6420, 6421, 7060 and 7061 all carry ROM word 0.
- Leading-zero blanking. DIGITS=4, value=16'h0070, blank_lz=1, S=1 -> no writes for digits 0 and 1; digits 2 and 3 written at x offsets 28 and 42; done at cycle 866.
- Colour key and clipping. Glyph column 0 set to TRANSPARENT and left=635 -> no writes for column 0 and none at x>=640; dst_addr never wraps.
- Handshake. start while busy and value changed mid-render -> ignored, output unchanged. Reset asserted at cycle 100 -> dst_wr=0 and busy=0 at the next edge, with no done pulse.
- scale=0 -> identical to scale=1. scale=7 -> identical to scale=MAX_SCALE.
